// File: rtl/icache_assoc.sv
// rtl/icache_assoc.sv - set-associative instruction cache with burst line refill
// One registered FSM sequences lookup, refill and response; tag/valid/data arrays are flops.
module icache_assoc #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int OFFSET_BITS = 4,
    parameter int INDEX_BITS  = 4,
    parameter int WAYS        = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ifu_r_valid_i,
    input  logic [ADDR_WIDTH-1:0] ifu_r_addr_i,
    output logic                  ifu_r_ready_o,
    output logic [DATA_WIDTH-1:0] ifu_r_data_o,
    input  logic                  flush_i,
    output logic                  Icache_r_valid_o,
    output logic [ADDR_WIDTH-1:0] Icache_r_addr_o,
    output logic [7:0]            Icache_r_len_o,
    input  logic                  Icache_r_ready_i,
    input  logic [DATA_WIDTH-1:0] Icache_r_data_i,
    input  logic                  Icache_r_last_i,
    output logic [31:0]           hit_cnt_o,
    output logic [31:0]           miss_cnt_o
);
    localparam int WPL    = 1 << (OFFSET_BITS - 2);
    localparam int SETS   = 1 << INDEX_BITS;
    localparam int TAG_W  = ADDR_WIDTH - OFFSET_BITS - INDEX_BITS;
    localparam int WORD_W = (OFFSET_BITS > 2) ? OFFSET_BITS - 2 : 1;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESP} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [SETS-1:0]       valid [WAYS];
    logic [TAG_W-1:0]      tag_mem [WAYS][SETS];
    logic [DATA_WIDTH-1:0] data_mem [WAYS][SETS][WPL];
    logic [WAY_W-1:0]      rr [SETS];
    logic [WAY_W-1:0]      victim;
    logic                  victim_evicts;
    logic [WORD_W-1:0]     beat;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  flush_pending;

    logic [TAG_W-1:0]      req_tag;
    logic [INDEX_BITS-1:0] req_index;
    logic [WORD_W-1:0]     req_word;
    logic                  hit;
    logic [WAY_W-1:0]      hit_way;
    logic [DATA_WIDTH-1:0] hit_word;
    logic [WAY_W-1:0]      miss_victim;
    logic                  miss_evicts;
    logic                  last_beat;
    logic [WAY_W-1:0]      rr_next;
    logic                  unused_last;

    assign req_tag     = req_addr[ADDR_WIDTH-1:OFFSET_BITS+INDEX_BITS];
    assign req_index   = req_addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
    assign req_word    = WORD_W'((req_addr >> 2) & ADDR_WIDTH'(WPL - 1));
    assign hit_word    = data_mem[hit_way][req_index][req_word];
    assign last_beat   = (beat == WORD_W'(WPL - 1));
    assign rr_next     = (victim == WAY_W'(WAYS - 1)) ? '0 : victim + 1'b1;
    assign Icache_r_len_o = 8'(WPL - 1);
    // Beat counting alone ends the burst; last is only a protocol echo.
    assign unused_last = Icache_r_last_i;

    always_comb begin
        hit         = 1'b0;
        hit_way     = '0;
        miss_victim = rr[req_index];
        miss_evicts = 1'b1;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[w][req_index] && tag_mem[w][req_index] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        // Descending scan leaves the lowest-numbered invalid way selected.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w][req_index]) begin
                miss_victim = WAY_W'(w);
                miss_evicts = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (state == REFILL && Icache_r_ready_i) begin
            data_mem[victim][req_index][beat] <= Icache_r_data_i;
            if (last_beat)
                tag_mem[victim][req_index] <= req_tag;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            req_addr         <= '0;
            victim           <= '0;
            victim_evicts    <= 1'b0;
            beat             <= '0;
            resp_data        <= '0;
            flush_pending    <= 1'b0;
            ifu_r_ready_o    <= 1'b0;
            ifu_r_data_o     <= '0;
            Icache_r_valid_o <= 1'b0;
            Icache_r_addr_o  <= '0;
            hit_cnt_o        <= '0;
            miss_cnt_o       <= '0;
            for (int w = 0; w < WAYS; w++)
                valid[w] <= '0;
            for (int s = 0; s < SETS; s++)
                rr[s] <= '0;
        end else begin
            if (flush_i && state != IDLE)
                flush_pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (flush_pending || flush_i) begin
                        for (int w = 0; w < WAYS; w++)
                            valid[w] <= '0;
                        flush_pending <= 1'b0;
                    end else if (ifu_r_valid_i) begin
                        req_addr <= ifu_r_addr_i;
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        hit_cnt_o     <= hit_cnt_o + 1'b1;
                        ifu_r_ready_o <= 1'b1;
                        ifu_r_data_o  <= hit_word;
                        state         <= RESP;
                    end else begin
                        victim           <= miss_victim;
                        victim_evicts    <= miss_evicts;
                        miss_cnt_o       <= miss_cnt_o + 1'b1;
                        beat             <= '0;
                        Icache_r_valid_o <= 1'b1;
                        Icache_r_addr_o  <= {req_addr[ADDR_WIDTH-1:OFFSET_BITS], OFFSET_BITS'(0)};
                        state            <= REFILL;
                    end
                end
                REFILL: begin
                    if (Icache_r_ready_i) begin
                        beat <= beat + 1'b1;
                        if (beat == req_word)
                            resp_data <= Icache_r_data_i;
                        if (last_beat) begin
                            valid[victim][req_index] <= 1'b1;
                            if (victim_evicts)
                                rr[req_index] <= rr_next;
                            Icache_r_valid_o <= 1'b0;
                            Icache_r_addr_o  <= '0;
                            ifu_r_ready_o    <= 1'b1;
                            ifu_r_data_o     <= (beat == req_word) ? Icache_r_data_i : resp_data;
                            state            <= RESP;
                        end
                    end
                end
                RESP: begin
                    ifu_r_ready_o <= 1'b0;
                    ifu_r_data_o  <= '0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_assoc.sv
// tb/tb_icache_assoc.sv - self-checking bench for icache_assoc
// Directed table, reset/flush sequences, then random fetches against a set/way reference model.
module tb_icache_assoc;
    localparam int WPL = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ifu_r_valid_i = 1'b0;
    logic [31:0] ifu_r_addr_i = '0;
    logic        ifu_r_ready_o;
    logic [31:0] ifu_r_data_o;
    logic        flush_i = 1'b0;
    logic        Icache_r_valid_o;
    logic [31:0] Icache_r_addr_o;
    logic [7:0]  Icache_r_len_o;
    logic        Icache_r_ready_i = 1'b0;
    logic [31:0] Icache_r_data_i = '0;
    logic        Icache_r_last_i = 1'b0;
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;

    always #5 clock = ~clock;

    icache_assoc dut (
        .clock(clock), .reset(reset),
        .ifu_r_valid_i(ifu_r_valid_i), .ifu_r_addr_i(ifu_r_addr_i),
        .ifu_r_ready_o(ifu_r_ready_o), .ifu_r_data_o(ifu_r_data_o),
        .flush_i(flush_i),
        .Icache_r_valid_o(Icache_r_valid_o), .Icache_r_addr_o(Icache_r_addr_o),
        .Icache_r_len_o(Icache_r_len_o), .Icache_r_ready_i(Icache_r_ready_i),
        .Icache_r_data_i(Icache_r_data_i), .Icache_r_last_i(Icache_r_last_i),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    int n_vec = 0;
    int n_cmp = 0;
    int n_err = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    bit gaps_en = 1'b0;

    bit          m_valid [16][2];
    logic [23:0] m_tag [16][2];
    int          m_rr [16];

    typedef struct {
        logic [31:0] addr;
        int          mode;
        bit          hit;
        logic [31:0] data;
    } vec_t;
    vec_t tbl [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h8000000)
            return 32'h11 * (32'(a[3:2]) + 32'd1);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic model_flush();
        for (int s = 0; s < 16; s++)
            for (int w = 0; w < 2; w++)
                m_valid[s][w] = 1'b0;
    endtask

    task automatic model_reset();
        model_flush();
        for (int s = 0; s < 16; s++)
            m_rr[s] = 0;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    // Hit if any valid way holds the tag; otherwise fill the lowest empty way, else evict m_rr.
    task automatic model_access(input logic [31:0] a, output bit hit);
        int s;
        int v;
        logic [23:0] t;
        s   = int'(a[7:4]);
        t   = a[31:8];
        hit = 1'b0;
        v   = -1;
        for (int w = 0; w < 2; w++)
            if (m_valid[s][w] && m_tag[s][w] == t)
                hit = 1'b1;
        if (!hit) begin
            for (int w = 1; w >= 0; w--)
                if (!m_valid[s][w])
                    v = w;
            if (v < 0) begin
                v = m_rr[s];
                m_rr[s] = (v + 1) % 2;
            end
            m_valid[s][v] = 1'b1;
            m_tag[s][v]   = t;
        end
    endtask

    // mode: 0 plain, 1 flush pulse in IDLE first, 2 flush with the request, 3 flush on beat 1
    task automatic do_fetch(input logic [31:0] addr, input int mode, input bit exp_hit,
                            input logic [31:0] exp_data);
        int cyc;
        int beat;
        int last_cyc;
        bit done;
        bit saw_burst;
        logic [31:0] base;
        base = {addr[31:4], 4'h0};
        n_vec++;
        if (exp_hit) exp_hits++;
        else exp_misses++;
        if (mode == 1) begin
            flush_i = 1'b1;
            @(negedge clock);
            flush_i = 1'b0;
        end
        ifu_r_valid_i = 1'b1;
        ifu_r_addr_i  = addr;
        if (mode == 2) flush_i = 1'b1;
        cyc = 0; beat = 0; last_cyc = -100; done = 1'b0; saw_burst = 1'b0;
        while (!done && cyc < 100) begin
            @(negedge clock);
            cyc++;
            flush_i          = 1'b0;
            Icache_r_ready_i = 1'b0;
            Icache_r_last_i  = 1'b0;
            Icache_r_data_i  = '0;
            if (ifu_r_ready_o) begin
                done = 1'b1;
                ifu_r_valid_i = 1'b0;
                check("resp_data", ifu_r_data_o, exp_data);
                check("hit_vs_miss", 32'(!saw_burst), 32'(exp_hit));
                check("hit_cnt", hit_cnt_o, 32'(exp_hits));
                check("miss_cnt", miss_cnt_o, 32'(exp_misses));
                if (saw_burst) begin
                    check("beats_taken", 32'(beat), 32'(WPL));
                    check("miss_latency", 32'(cyc), 32'(last_cyc + 1));
                    check("burst_valid_dropped", 32'(Icache_r_valid_o), 32'd0);
                end else if (mode == 0) begin
                    check("hit_latency", 32'(cyc), 32'd2);
                end
            end else if (Icache_r_valid_o) begin
                if (!saw_burst) begin
                    check("burst_addr", Icache_r_addr_o, base);
                    check("burst_len", 32'(Icache_r_len_o), 32'(WPL - 1));
                end
                saw_burst = 1'b1;
                if (beat >= WPL) begin
                    n_cmp++; n_err++;
                    $display("FAIL burst_overrun: valid still high after last beat at 0x%08h", base);
                    done = 1'b1;
                    ifu_r_valid_i = 1'b0;
                end else if (!(gaps_en && $urandom_range(0, 3) == 0)) begin
                    Icache_r_ready_i = 1'b1;
                    Icache_r_data_i  = mem_word(base + 32'(4 * beat));
                    Icache_r_last_i  = (beat == WPL - 1);
                    if (mode == 3 && beat == 1) flush_i = 1'b1;
                    last_cyc = cyc;
                    beat++;
                end
            end
        end
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL fetch_timeout: no ready for 0x%08h after %0d cycles", addr, cyc);
            ifu_r_valid_i = 1'b0;
        end
        @(negedge clock);
        check("ready_one_cycle", 32'(ifu_r_ready_o), 32'd0);
        check("data_zero_idle", ifu_r_data_o, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(ifu_r_ready_o), 32'd0);
        check({tag, "_data"}, ifu_r_data_o, 32'd0);
        check({tag, "_rvalid"}, 32'(Icache_r_valid_o), 32'd0);
        check({tag, "_raddr"}, Icache_r_addr_o, 32'd0);
        check({tag, "_hits"}, hit_cnt_o, 32'd0);
        check({tag, "_misses"}, miss_cnt_o, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr;
        int mode;
        int cnt;
        bit hit;

        tbl[0]  = '{32'h80000004, 0, 1'b0, 32'h22};
        tbl[1]  = '{32'h8000000C, 0, 1'b1, 32'h44};
        tbl[2]  = '{32'h80000100, 0, 1'b0, mem_word(32'h80000100)};
        tbl[3]  = '{32'h80000200, 0, 1'b0, mem_word(32'h80000200)};
        tbl[4]  = '{32'h80000000, 0, 1'b0, 32'h11};
        tbl[5]  = '{32'h80000200, 0, 1'b1, mem_word(32'h80000200)};
        tbl[6]  = '{32'h80000100, 0, 1'b0, mem_word(32'h80000100)};
        tbl[7]  = '{32'h80000008, 0, 1'b1, 32'h33};
        tbl[8]  = '{32'h80000000, 1, 1'b0, 32'h11};
        tbl[9]  = '{32'h80000104, 3, 1'b0, mem_word(32'h80000104)};
        tbl[10] = '{32'h80000104, 0, 1'b0, mem_word(32'h80000104)};
        tbl[11] = '{32'h80000104, 0, 1'b1, mem_word(32'h80000104)};
        tbl[12] = '{32'h80000104, 2, 1'b0, mem_word(32'h80000104)};
        tbl[13] = '{32'h80000010, 0, 1'b0, 32'h0010FFEF};
        tbl[14] = '{32'h8000001C, 0, 1'b1, mem_word(32'h8000001C)};

        repeat (2) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 15; i++)
            do_fetch(tbl[i].addr, tbl[i].mode, tbl[i].hit, tbl[i].data);

        // Async reset two beats into a burst, then the same fetch must restart from the line base.
        ifu_r_valid_i = 1'b1;
        ifu_r_addr_i  = 32'h80000404;
        cnt = 0;
        while (!Icache_r_valid_o && cnt < 20) begin
            @(negedge clock);
            cnt++;
        end
        check("midburst_started", 32'(Icache_r_valid_o), 32'd1);
        for (int b = 0; b < 2; b++) begin
            Icache_r_ready_i = 1'b1;
            Icache_r_data_i  = mem_word(32'h80000400 + 32'(4 * b));
            Icache_r_last_i  = 1'b0;
            @(negedge clock);
        end
        Icache_r_ready_i = 1'b0;
        Icache_r_data_i  = '0;
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        do_fetch(32'h80000404, 0, 1'b0, mem_word(32'h80000404));

        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        gaps_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            addr = 32'h80000000 | ($urandom_range(0, 3) << 8) | ($urandom_range(0, 1) << 4)
                 | ($urandom_range(0, 3) << 2);
            cnt  = $urandom_range(0, 9);
            mode = (cnt == 0) ? 1 : (cnt == 1) ? 2 : 0;
            if (mode != 0) model_flush();
            model_access(addr, hit);
            if (mode == 0 && !hit && $urandom_range(0, 3) == 0) mode = 3;
            if (mode == 3) model_flush();
            do_fetch(addr, mode, hit, mem_word(addr));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
